// File: rtl/river_pkg.sv
// river_pkg: constants and helpers shared by the river renderer.
//   - default stream geometry (centre, oscillation, width)
//   - default foam channel tables (channel 0 in the LSBs)
//   - default foam wrap period
//   - foam_field(): pulls one field out of a packed foam table
//   - offset_entry(): contents of the stream offset table
package river_pkg;

  localparam int STREAM_CENTER_DEF = 110;
  localparam int STREAM_OSC_DEF    = 30;
  localparam int STREAM_WIDTH_DEF  = 90;
  localparam int WINDOW_HEIGHT_DEF = 512;

  // Widest packed foam table: 8 channels of 10-bit fields.
  localparam int FOAM_TBL_W = 80;

  localparam logic [23:0] FOAM_X_DEF  = {8'd75,  8'd40,   8'd20};
  localparam logic [29:0] FOAM_Y0_DEF = {10'd0,  10'd300, 10'd100};
  localparam logic [29:0] FOAM_Y1_DEF = {10'd200, 10'd450, 10'd250};

  // Field idx of width fw from a packed table, zero-extended to 10 bits.
  function automatic logic [9:0] foam_field(input logic [FOAM_TBL_W-1:0] tbl,
                                            input int idx, input int fw);
    logic [FOAM_TBL_W-1:0] s;
    s = tbl >> (idx * fw);
    return s[9:0] & 10'((1 << fw) - 1);
  endfunction

  // Offset table: triangle wave of period 64 (0..31..0), phase 10, so
  // entry 0 is 10 and entries 53/54 are 0.
  function automatic int offset_entry(input int addr);
    int p;
    p = (addr + 10) % 64;
    return (p < 32) ? p : 63 - p;
  endfunction

endpackage

// File: rtl/river_offset_rom.sv
// river_offset_rom: stream x-offset table, synchronous read.
//   clk  - system clock
//   addr - table address (ADDR_W)
//   data - offset for the address presented on the previous edge (OFS_W)
module river_offset_rom
  import river_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int OFS_W  = 7
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [OFS_W-1:0]  data
);

  // NOTE: table read data carries no reset; consumers qualify it with the
  // pipeline valid bit, so a stale value is never observed.
  always_ff @(posedge clk) begin
    data <= OFS_W'(offset_entry(int'(addr)));
  end

endmodule

// File: rtl/river_scroller.sv
// river_scroller: per-pixel river / foam masks with programmable scroll,
// plus a frame-latched "car overlapped water" flag.
//   clk, reset_n          - clock, synchronous active-low reset
//   pixel_x/y, pixel_valid - pixel stream in; outputs follow 2 edges later
//   frame_end             - one-cycle pulse after the last pixel of a frame
//   update_signal, pause, speed - scroll step control
//   car_x0/x1/y0/y1       - inclusive car box (empty when x0>x1 or y0>y1)
//   is_on, is_on_foam, out_valid - registered pixel results
//   car_in_water          - water overlap of the previous frame
module river_scroller
  import river_pkg::*;
#(
  parameter int PIX_W         = 10,
  parameter int ADDR_W        = 8,
  parameter int OFS_W         = 7,
  parameter int STREAM_CENTER = STREAM_CENTER_DEF,
  parameter int STREAM_OSC    = STREAM_OSC_DEF,
  parameter int STREAM_WIDTH  = STREAM_WIDTH_DEF,
  parameter int WINDOW_HEIGHT = WINDOW_HEIGHT_DEF,
  parameter int SPEED_W       = 3,
  parameter int NUM_FOAMS     = 3,
  parameter int FOAM_WIDTH    = 5,
  parameter logic [NUM_FOAMS*8-1:0]  FOAM_X  = FOAM_X_DEF,
  parameter logic [NUM_FOAMS*10-1:0] FOAM_Y0 = FOAM_Y0_DEF,
  parameter logic [NUM_FOAMS*10-1:0] FOAM_Y1 = FOAM_Y1_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PIX_W-1:0]   pixel_x,
  input  logic [PIX_W-1:0]   pixel_y,
  input  logic               pixel_valid,
  input  logic               frame_end,
  input  logic               update_signal,
  input  logic               pause,
  input  logic [SPEED_W-1:0] speed,
  input  logic [PIX_W-1:0]   car_x0,
  input  logic [PIX_W-1:0]   car_x1,
  input  logic [PIX_W-1:0]   car_y0,
  input  logic [PIX_W-1:0]   car_y1,
  output logic               is_on,
  output logic               is_on_foam,
  output logic               out_valid,
  output logic               car_in_water
);

  localparam int WIN_W = $clog2(WINDOW_HEIGHT);
  // Stream position plus width and foam offsets never overflow this width.
  localparam int SP_W  = PIX_W + 2;

  logic [ADDR_W-1:0]    shift_reg;
  logic [WIN_W-1:0]     window_reg;
  logic [ADDR_W-1:0]    rom_addr;
  logic [OFS_W-1:0]     rom_ofs;

  logic                 s1_valid;
  logic [PIX_W-1:0]     s1_x;
  logic [PIX_W-1:0]     s1_y;
  logic [WIN_W-1:0]     s1_yp;

  logic [SP_W-1:0]      x_ext;
  logic [SP_W-1:0]      stream_pos;
  logic [NUM_FOAMS-1:0] foam_hit;
  logic                 is_on_comb;
  logic                 foam_comb;
  logic                 car_hit;

  logic                 hit_accum;
  logic                 fe_d1;
  logic                 fe_d2;

  // ---------------- scroll state ----------------
  // NOTE: state registers use non-blocking assignments so every register
  // sees pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_reg  <= '0;
      window_reg <= '0;
    end else if (update_signal && !pause) begin
      shift_reg  <= shift_reg - ADDR_W'(speed);
      window_reg <= WIN_W'((int'(window_reg) + int'(speed)) % WINDOW_HEIGHT);
    end
  end

  // ---------------- stage 1 ----------------
  // The table is indexed by screen y shifted by the scroll position.
  assign rom_addr = shift_reg + ADDR_W'(pixel_y);

  river_offset_rom #(
    .ADDR_W (ADDR_W),
    .OFS_W  (OFS_W)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_ofs)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_yp    <= '0;
    end else begin
      s1_valid <= pixel_valid;
      s1_x     <= pixel_x;
      s1_y     <= pixel_y;
      s1_yp    <= WIN_W'((int'(pixel_y) + int'(window_reg)) % WINDOW_HEIGHT);
    end
  end

  // ---------------- stage 2 ----------------
  assign x_ext      = SP_W'(s1_x);
  assign stream_pos = SP_W'(STREAM_CENTER - STREAM_OSC) + SP_W'(rom_ofs);
  assign is_on_comb = (x_ext >= stream_pos) &&
                      (x_ext <= stream_pos + SP_W'(STREAM_WIDTH));

  for (genvar i = 0; i < NUM_FOAMS; i++) begin : g_foam
    localparam logic [9:0] FX  = foam_field(FOAM_TBL_W'(FOAM_X),  i, 8);
    localparam logic [9:0] FY0 = foam_field(FOAM_TBL_W'(FOAM_Y0), i, 10);
    localparam logic [9:0] FY1 = foam_field(FOAM_TBL_W'(FOAM_Y1), i, 10);
    logic [SP_W-1:0] fx_lo;
    assign fx_lo       = stream_pos + SP_W'(FX);
    assign foam_hit[i] = (x_ext >= fx_lo) &&
                         (x_ext <= fx_lo + SP_W'(FOAM_WIDTH)) &&
                         (int'(s1_yp) >= int'(FY0)) &&
                         (int'(s1_yp) <= int'(FY1));
  end

  assign foam_comb = |foam_hit;

  // An inverted box fails one of the range tests, so it never hits.
  assign car_hit = s1_valid && is_on_comb &&
                   (s1_x >= car_x0) && (s1_x <= car_x1) &&
                   (s1_y >= car_y0) && (s1_y <= car_y1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      is_on      <= 1'b0;
      is_on_foam <= 1'b0;
    end else begin
      out_valid  <= s1_valid;
      is_on      <= s1_valid && is_on_comb;
      is_on_foam <= s1_valid && foam_comb;
    end
  end

  // ---------------- frame hit flag ----------------
  // frame_end is delayed to line up with stage 2, so a pixel arriving with
  // the pulse has already reached hit_accum when the delayed pulse fires.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fe_d1        <= 1'b0;
      fe_d2        <= 1'b0;
      hit_accum    <= 1'b0;
      car_in_water <= 1'b0;
    end else begin
      fe_d1 <= frame_end;
      fe_d2 <= fe_d1;
      if (fe_d2) begin
        car_in_water <= hit_accum | car_hit;
        hit_accum    <= 1'b0;
      end else if (car_hit) begin
        hit_accum <= 1'b1;
      end
    end
  end

endmodule
